legv8_multicycle_ctrl: RTL and testbench

Multi-cycle sequencer for the LEGv8 datapath. It latches each fetched instruction, decodes it, and steps the register file, ALU, data memory and PC through per-class state sequences. It replaces the single-state FSM_Controller decode and drives the same datapath controls (read_reg_1/2, write_reg, reg_write_rf, mux2, mux3, alu_op, mem_read_dm, mem_write_dm). It adds fetch/memory handshakes, PC control and a retired-instruction counter.

---
 rtl/legv8_multicycle_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_legv8_multicycle_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/legv8_multicycle_ctrl.sv
// legv8_multicycle_ctrl
//   Multi-cycle sequencer for the LEGv8 datapath. It latches each fetched
//   instruction into ir_out, decodes it, and walks the register file, ALU,
//   data memory and PC through a per-class state sequence.
//
//   Inputs : clk, reset (synchronous, active high), instruction, im_ready,
//            dm_ready, alu_zero
//   Outputs: ir_out, read_reg_1/2, write_reg, reg_write_rf, mux2, mux3,
//            imm_sel, alu_op, mem_read_dm, mem_write_dm, im_req, pc_write,
//            pc_src, instr_done, trap, retired, state
//
//   Datapath controls come from state and ir_out only. Three handshake
//   outputs also look at inputs:
//     - pc_write in FETCH follows im_ready (PC+4 only when a fetch lands)
//     - pc_write in BRANCH follows alu_zero for CBZ
//     - instr_done in MEM_WR follows dm_ready (the store retires when it completes)
module legv8_multicycle_ctrl #(
   parameter int RET_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      instruction,
   input  logic             im_ready,
   input  logic             dm_ready,
   input  logic             alu_zero,
   output logic [31:0]      ir_out,
   output logic [4:0]       read_reg_1,
   output logic [4:0]       read_reg_2,
   output logic [4:0]       write_reg,
   output logic             reg_write_rf,
   output logic             mux2,
   output logic             mux3,
   output logic [1:0]       imm_sel,
   output logic [2:0]       alu_op,
   output logic             mem_read_dm,
   output logic             mem_write_dm,
   output logic             im_req,
   output logic             pc_write,
   output logic             pc_src,
   output logic             instr_done,
   output logic             trap,
   output logic [RET_W-1:0] retired,
   output logic [3:0]       state
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_EXEC_R = 4'd2,
      S_ADDR   = 4'd3,
      S_MEM_RD = 4'd4,
      S_MEM_WR = 4'd5,
      S_WB_R   = 4'd6,
      S_WB_LD  = 4'd7,
      S_BRANCH = 4'd8,
      S_TRAP   = 4'd9
   } state_t;

   state_t           state_q, state_d;
   logic [31:0]      ir_q, ir_d;
   logic [RET_W-1:0] retired_q, retired_d;
   logic             trap_q, trap_d;

   // ---------------- decode of the latched instruction ----------------
   logic [10:0] op11;
   logic        is_add, is_sub, is_and, is_orr, is_r;
   logic        is_ld, is_st, is_cbz, is_b;
   logic [2:0]  r_alu_op;

   assign op11   = ir_q[31:21];
   assign is_add = (op11 == 11'b10001011000);
   assign is_sub = (op11 == 11'b11001011000);
   assign is_and = (op11 == 11'b10001010000);
   assign is_orr = (op11 == 11'b10101010000);
   assign is_r   = is_add | is_sub | is_and | is_orr;
   assign is_ld  = (op11 == 11'b11111000010);
   assign is_st  = (op11 == 11'b11111000000);
   assign is_cbz = (ir_q[31:24] == 8'b10110100);
   assign is_b   = (ir_q[31:26] == 6'b000101);

   always_comb begin
      r_alu_op = 3'b010;
      if (is_sub)      r_alu_op = 3'b110;
      else if (is_and) r_alu_op = 3'b000;
      else if (is_orr) r_alu_op = 3'b001;
   end

   // Register fields are fixed positions; only read_reg_2 moves, because
   // STUR and CBZ carry their source register in Rt.
   assign read_reg_1 = ir_q[9:5];
   assign read_reg_2 = (is_st | is_cbz) ? ir_q[4:0] : ir_q[20:16];
   assign write_reg  = ir_q[4:0];

   // ---------------- next state and controls ----------------
   always_comb begin
      state_d      = state_q;
      ir_d         = ir_q;
      trap_d       = trap_q;
      reg_write_rf = 1'b0;
      mux2         = 1'b0;
      mux3         = 1'b0;
      imm_sel      = 2'b00;
      alu_op       = 3'b000;
      mem_read_dm  = 1'b0;
      mem_write_dm = 1'b0;
      im_req       = 1'b0;
      pc_write     = 1'b0;
      pc_src       = 1'b0;
      instr_done   = 1'b0;

      unique case (state_q)
         S_FETCH: begin
            im_req = 1'b1;
            if (im_ready) begin
               ir_d     = instruction;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end
         end
         S_DECODE: begin
            if (is_r)                state_d = S_EXEC_R;
            else if (is_ld || is_st) state_d = S_ADDR;
            else if (is_cbz || is_b) state_d = S_BRANCH;
            else begin
               state_d = S_TRAP;
               trap_d  = 1'b1;
            end
         end
         S_EXEC_R: begin
            alu_op  = r_alu_op;
            state_d = S_WB_R;
         end
         S_WB_R: begin
            alu_op       = r_alu_op;
            reg_write_rf = 1'b1;
            instr_done   = 1'b1;
            state_d      = S_FETCH;
         end
         S_ADDR: begin
            alu_op  = 3'b010;
            mux3    = 1'b1;
            imm_sel = 2'b01;
            state_d = is_ld ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            alu_op      = 3'b010;
            mux3        = 1'b1;
            imm_sel     = 2'b01;
            mem_read_dm = 1'b1;
            if (dm_ready) state_d = S_WB_LD;
         end
         S_WB_LD: begin
            mux2         = 1'b1;
            reg_write_rf = 1'b1;
            instr_done   = 1'b1;
            state_d      = S_FETCH;
         end
         S_MEM_WR: begin
            alu_op       = 3'b010;
            mux3         = 1'b1;
            imm_sel      = 2'b01;
            mem_write_dm = 1'b1;
            if (dm_ready) begin
               instr_done = 1'b1;
               state_d    = S_FETCH;
            end
         end
         S_BRANCH: begin
            pc_src     = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
            if (is_b) begin
               imm_sel  = 2'b11;
               pc_write = 1'b1;
            end else begin
               // CBZ: pass Rt through the ALU so alu_zero reflects Rt == 0
               imm_sel  = 2'b10;
               alu_op   = 3'b111;
               pc_write = alu_zero;
            end
         end
         S_TRAP: begin
            state_d = S_TRAP;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase

      // A reset cycle must never let a store or register write escape, even
      // though the state register still holds the interrupted state.
      if (reset) begin
         reg_write_rf = 1'b0;
         mux2         = 1'b0;
         mux3         = 1'b0;
         imm_sel      = 2'b00;
         alu_op       = 3'b000;
         mem_read_dm  = 1'b0;
         mem_write_dm = 1'b0;
         im_req       = 1'b0;
         pc_write     = 1'b0;
         pc_src       = 1'b0;
         instr_done   = 1'b0;
      end

      retired_d = instr_done ? retired_q + RET_W'(1) : retired_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_FETCH;
         ir_q      <= '0;
         retired_q <= '0;
         trap_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ir_q      <= ir_d;
         retired_q <= retired_d;
         trap_q    <= trap_d;
      end
   end

   assign ir_out  = ir_q;
   assign trap    = trap_q;
   assign retired = retired_q;
   assign state   = state_q;

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
module tb_legv8_multicycle_ctrl;

   localparam int RW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [31:0]   instruction;
   logic          im_ready, dm_ready, alu_zero;
   logic [31:0]   ir_out;
   logic [4:0]    read_reg_1, read_reg_2, write_reg;
   logic          reg_write_rf, mux2, mux3;
   logic [1:0]    imm_sel;
   logic [2:0]    alu_op;
   logic          mem_read_dm, mem_write_dm, im_req, pc_write, pc_src;
   logic          instr_done, trap;
   logic [RW-1:0] retired;
   logic [3:0]    state;

   int total = 0;
   int bad   = 0;

   legv8_multicycle_ctrl #(.RET_W(RW)) dut (
      .clk(clk), .reset(reset), .instruction(instruction),
      .im_ready(im_ready), .dm_ready(dm_ready), .alu_zero(alu_zero),
      .ir_out(ir_out), .read_reg_1(read_reg_1), .read_reg_2(read_reg_2),
      .write_reg(write_reg), .reg_write_rf(reg_write_rf), .mux2(mux2),
      .mux3(mux3), .imm_sel(imm_sel), .alu_op(alu_op),
      .mem_read_dm(mem_read_dm), .mem_write_dm(mem_write_dm),
      .im_req(im_req), .pc_write(pc_write), .pc_src(pc_src),
      .instr_done(instr_done), .trap(trap), .retired(retired), .state(state)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
   endtask

   // Present one instruction in FETCH; returns in DECODE with im_ready low.
   task automatic fetch(input logic [31:0] ins);
      instruction = ins;
      im_ready    = 1'b1;
      step();
      im_ready    = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; instruction = 32'h0; im_ready = 1'b0; dm_ready = 1'b0; alu_zero = 1'b0;
      step();
      total++; if (state !== 4'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", state); end
      total++; if (ir_out !== 32'h0) begin bad++; $display("FAIL rst_ir got=%h exp=0", ir_out); end
      total++; if (retired !== 4'd0) begin bad++; $display("FAIL rst_retired got=%0d exp=0", retired); end
      total++; if (trap !== 1'b0) begin bad++; $display("FAIL rst_trap got=%b exp=0", trap); end
      total++; if ({reg_write_rf, mem_write_dm, mem_read_dm, pc_write, im_req, instr_done} !== 6'b0)
         begin bad++; $display("FAIL rst_strobes got=%b exp=000000", {reg_write_rf, mem_write_dm, mem_read_dm, pc_write, im_req, instr_done}); end
      total++; if ({alu_op, imm_sel, mux2, mux3} !== 7'b0) begin bad++; $display("FAIL rst_ctrl got=%b exp=0", {alu_op, imm_sel, mux2, mux3}); end
      reset = 1'b0;
      #1;
      total++; if (im_req !== 1'b1) begin bad++; $display("FAIL rst_fetch_req got=%b exp=1", im_req); end
   endtask

   task automatic test_r_type();
      do_reset();
      fetch(32'hCB030046);  // SUB X6, X2, X3
      total++; if (state !== 4'd1) begin bad++; $display("FAIL sub_decode got=%0d exp=1", state); end
      step();
      total++; if (state !== 4'd2) begin bad++; $display("FAIL sub_exec got=%0d exp=2", state); end
      total++; if (alu_op !== 3'b110 || mux3 !== 1'b0 || reg_write_rf !== 1'b0)
         begin bad++; $display("FAIL sub_exec_ctrl got=%b/%b/%b exp=110/0/0", alu_op, mux3, reg_write_rf); end
      step();
      total++; if (state !== 4'd6) begin bad++; $display("FAIL sub_wb got=%0d exp=6", state); end
      total++; if ({read_reg_1, read_reg_2, write_reg} !== {5'd2, 5'd3, 5'd6})
         begin bad++; $display("FAIL sub_regs got=%0d,%0d,%0d exp=2,3,6", read_reg_1, read_reg_2, write_reg); end
      total++; if (alu_op !== 3'b110 || reg_write_rf !== 1'b1 || mux2 !== 1'b0 || instr_done !== 1'b1)
         begin bad++; $display("FAIL sub_wb_ctrl got=%b/%b/%b/%b exp=110/1/0/1", alu_op, reg_write_rf, mux2, instr_done); end
      step();
      total++; if (state !== 4'd0 || reg_write_rf !== 1'b0)
         begin bad++; $display("FAIL sub_back got=%0d/%b exp=0/0", state, reg_write_rf); end
      total++; if (retired !== 4'd1) begin bad++; $display("FAIL sub_retired got=%0d exp=1", retired); end
   endtask

   task automatic test_load();
      int cyc = 1;
      int mrd = 0;
      dm_ready = 1'b0;
      fetch(32'hF840C002);  // LDUR X2, [X0, #12]
      while (state !== 4'd0 && cyc < 20) begin
         cyc++;
         if (state === 4'd4) begin
            mrd++;
            total++; if (mem_read_dm !== 1'b1 || mux3 !== 1'b1 || imm_sel !== 2'b01 || alu_op !== 3'b010)
               begin bad++; $display("FAIL ld_memrd got=%b/%b/%b/%b exp=1/1/01/010", mem_read_dm, mux3, imm_sel, alu_op); end
            if (mrd == 4) dm_ready = 1'b1;
         end
         if (state === 4'd7) begin
            total++; if (mux2 !== 1'b1 || write_reg !== 5'd2 || reg_write_rf !== 1'b1)
               begin bad++; $display("FAIL ld_wb got=%b/%0d/%b exp=1/2/1", mux2, write_reg, reg_write_rf); end
         end
         step();
      end
      dm_ready = 1'b0;
      total++; if (mrd != 4) begin bad++; $display("FAIL ld_memrd_cycles got=%0d exp=4", mrd); end
      total++; if (cyc != 8) begin bad++; $display("FAIL ld_latency got=%0d exp=8", cyc); end
      total++; if (retired !== 4'd2) begin bad++; $display("FAIL ld_retired got=%0d exp=2", retired); end
   endtask

   task automatic test_cbz();
      for (int z = 1; z >= 0; z--) begin
         alu_zero = z[0];
         fetch(32'hB4000062);  // CBZ X2, +3
         step();
         total++; if (state !== 4'd8) begin bad++; $display("FAIL cbz_state z=%0d got=%0d exp=8", z, state); end
         total++; if (pc_write !== z[0] || pc_src !== 1'b1 || imm_sel !== 2'b10 || read_reg_2 !== 5'd2)
            begin bad++; $display("FAIL cbz_ctrl z=%0d got=%b/%b/%b/%0d exp=%0d/1/10/2", z, pc_write, pc_src, imm_sel, read_reg_2, z); end
         total++; if (alu_op !== 3'b111 || mux3 !== 1'b0 || instr_done !== 1'b1 || reg_write_rf !== 1'b0)
            begin bad++; $display("FAIL cbz_alu z=%0d got=%b/%b/%b/%b exp=111/0/1/0", z, alu_op, mux3, instr_done, reg_write_rf); end
         step();
      end
      alu_zero = 1'b0;
      total++; if (state !== 4'd0 || retired !== 4'd4)
         begin bad++; $display("FAIL cbz_retired got=%0d/%0d exp=0/4", state, retired); end
   endtask

   task automatic test_trap();
      fetch(32'hFFFFFFFF);
      step();
      total++; if (state !== 4'd9 || trap !== 1'b1) begin bad++; $display("FAIL trap_enter got=%0d/%b exp=9/1", state, trap); end
      im_ready = 1'b1;
      step(); step(); step();
      total++; if (state !== 4'd9 || trap !== 1'b1 || im_req !== 1'b0 || instr_done !== 1'b0)
         begin bad++; $display("FAIL trap_sticky got=%0d/%b/%b/%b exp=9/1/0/0", state, trap, im_req, instr_done); end
      total++; if (retired !== 4'd4) begin bad++; $display("FAIL trap_retired got=%0d exp=4", retired); end
      im_ready = 1'b0;
      do_reset();
      total++; if (state !== 4'd0 || trap !== 1'b0) begin bad++; $display("FAIL trap_clear got=%0d/%b exp=0/0", state, trap); end
   endtask

   task automatic test_reset_in_store();
      dm_ready = 1'b0;
      fetch(32'hF8000062);  // STUR X2, [X3, #0]
      step(); step();
      total++; if (state !== 4'd5 || mem_write_dm !== 1'b1)
         begin bad++; $display("FAIL st_memwr got=%0d/%b exp=5/1", state, mem_write_dm); end
      reset = 1'b1;
      #1;
      total++; if (mem_write_dm !== 1'b0) begin bad++; $display("FAIL st_rst_cycle_wr got=%b exp=0", mem_write_dm); end
      step();
      reset = 1'b0;
      #1;
      total++; if (state !== 4'd0 || mem_write_dm !== 1'b0 || retired !== 4'd0)
         begin bad++; $display("FAIL st_after_rst got=%0d/%b/%0d exp=0/0/0", state, mem_write_dm, retired); end
   endtask

   task automatic test_back_to_back();
      int pulses = 0;
      do_reset();
      instruction = 32'h14000001;  // B +1
      im_ready    = 1'b1;
      for (int i = 0; i < 48; i++) begin
         total++; if (instr_done !== (i % 3 == 2))
            begin bad++; $display("FAIL b2b_done cyc=%0d got=%b exp=%0d", i, instr_done, (i % 3 == 2)); end
         if (instr_done === 1'b1) pulses++;
         if (i == 2) begin
            total++; if (pc_write !== 1'b1 || pc_src !== 1'b1 || imm_sel !== 2'b11)
               begin bad++; $display("FAIL b_ctrl got=%b/%b/%b exp=1/1/11", pc_write, pc_src, imm_sel); end
         end
         if (i == 45) begin
            total++; if (retired !== 4'd15) begin bad++; $display("FAIL b2b_pre_wrap got=%0d exp=15", retired); end
         end
         step();
      end
      im_ready = 1'b0;
      total++; if (pulses != 16) begin bad++; $display("FAIL b2b_pulses got=%0d exp=16", pulses); end
      total++; if (retired !== 4'd0) begin bad++; $display("FAIL b2b_wrap got=%0d exp=0", retired); end
   endtask

   initial begin
      test_reset();
      test_r_type();
      test_load();
      test_cbz();
      test_trap();
      test_reset_in_store();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
